// File: rtl/svi_bank_ctrl_if.sv
// Z80-side bus bundle for svi_bank_ctrl: CPU strobes in, decoded memory qualifiers out.
interface svi_bank_ctrl_if #(
  parameter int unsigned ADDR_W = 18
) ();
  logic [15:0]       cpu_addr_i;
  logic [7:0]        cpu_dout_i;
  logic              iorq_n_i;
  logic              mreq_n_i;
  logic              wr_n_i;
  logic [7:0]        regmap_o;
  logic [1:0]        bank_o;
  logic [ADDR_W-1:0] addr_o;
  logic              ram_o;
  logic              wp_o;
  logic              open_o;

  modport master (
    output cpu_addr_i, cpu_dout_i, iorq_n_i, mreq_n_i, wr_n_i,
    input  regmap_o, bank_o, addr_o, ram_o, wp_o, open_o
  );

  modport slave (
    input  cpu_addr_i, cpu_dout_i, iorq_n_i, mreq_n_i, wr_n_i,
    output regmap_o, bank_o, addr_o, ram_o, wp_o, open_o
  );
endinterface

// File: rtl/svi_bank_ctrl.sv
// SVI-318/328 bank controller: snoops PSG R15 writes, commits between memory cycles, decodes banks.
// Define SVI_SV807_EN to map the SV-807 expansion RAM (banks 22/31/32); otherwise those are open bus.
module svi_bank_ctrl #(
  parameter int unsigned ADDR_W        = 18,  // must be >= 18
  parameter bit          EXT_RAM       = 1'b1,
  parameter logic [7:0]  PSG_ADDR_PORT = 8'h88,
  parameter logic [7:0]  PSG_DATA_PORT = 8'h8C
) (
  input logic            clk_sys,
  input logic            reset_n,
  svi_bank_ctrl_if.slave bus
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StPend = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              io_wr_q, io_wr_d;
  logic [3:0]        idx_q, idx_d;
  logic [7:0]        pend_q, pend_d;
  logic [7:0]        regmap_q, regmap_d;
  logic [1:0]        bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ram_q, ram_d;
  logic              wp_q, wp_d;
  logic              open_q, open_d;

  logic io_ev;
  logic data_ev;
  logic sv807;

  assign io_wr_d = ~bus.iorq_n_i & ~bus.wr_n_i;
  assign io_ev   = io_wr_d & ~io_wr_q;
  assign data_ev = io_ev && (bus.cpu_addr_i[7:0] == PSG_DATA_PORT) && (idx_q == 4'd15);

  always_comb begin
    idx_d    = idx_q;
    pend_d   = pend_q;
    regmap_d = regmap_q;
    state_d  = state_q;
    if (io_ev && (bus.cpu_addr_i[7:0] == PSG_ADDR_PORT)) begin
      idx_d = bus.cpu_dout_i[3:0];
    end
    // A data write always wins over a commit so the last written value is the one kept.
    if (data_ev) begin
      pend_d  = bus.cpu_dout_i;
      state_d = StPend;
    end else if ((state_q == StPend) && bus.mreq_n_i) begin
      regmap_d = pend_q;
      state_d  = StIdle;
    end
  end

  // Register bits are active-low enables; first matching rule in each page wins.
  always_comb begin
    bank_d = 2'd0;
    ram_d  = 1'b0;
    open_d = 1'b0;
    sv807  = 1'b0;
    if (!bus.cpu_addr_i[15]) begin
      if (!regmap_q[0]) begin
        bank_d = 2'd1;
      end else if (!regmap_q[1]) begin
        bank_d = 2'd2;
        ram_d  = EXT_RAM;
        open_d = ~EXT_RAM;
      end else if (!regmap_q[3]) begin
        bank_d = 2'd3;
        sv807  = 1'b1;
      end
    end else begin
      if (!regmap_q[2]) begin
        bank_d = 2'd2;
        sv807  = 1'b1;
      end else if (!regmap_q[4]) begin
        bank_d = 2'd3;
        sv807  = 1'b1;
      end else if (!regmap_q[0] && (bus.cpu_addr_i[14] ? !regmap_q[7] : !regmap_q[6])) begin
        bank_d = 2'd1;
      end else begin
        ram_d = 1'b1;
      end
    end
    if (sv807) begin
`ifdef SVI_SV807_EN
      ram_d  = 1'b1;
`else
      open_d = 1'b1;
`endif
    end
    wp_d          = ~ram_d | open_d;
    addr_d        = '0;
    addr_d[17:0]  = {bank_d, bus.cpu_addr_i};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      io_wr_q  <= 1'b0;
      idx_q    <= 4'd0;
      pend_q   <= 8'h00;
      regmap_q <= 8'hFF;
      bank_q   <= 2'd0;
      addr_q   <= '0;
      ram_q    <= 1'b0;
      wp_q     <= 1'b1;
      open_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      io_wr_q  <= io_wr_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      regmap_q <= regmap_d;
      bank_q   <= bank_d;
      addr_q   <= addr_d;
      ram_q    <= ram_d;
      wp_q     <= wp_d;
      open_q   <= open_d;
    end
  end

  assign bus.regmap_o = regmap_q;
  assign bus.bank_o   = bank_q;
  assign bus.addr_o   = addr_q;
  assign bus.ram_o    = ram_q;
  assign bus.wp_o     = wp_q;
  assign bus.open_o   = open_q;

endmodule
